// File: rtl/fakeram_port_ctrl.sv
// Initiator-side controller for the single-port fakeram macro: request stream to macro pins,
// one-cycle read capture into a 2-entry in-order response buffer, and a zero-fill sweep after reset.
module fakeram_port_ctrl #(
  parameter int unsigned BITS       = 95,
  parameter int unsigned WORD_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_v_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [BITS-1:0]       req_data_in,
  input  logic [BITS-1:0]       req_mask_in,
  output logic                  rsp_v_out,
  output logic [BITS-1:0]       rsp_data_out,
  input  logic                  rsp_yumi_in,
  output logic                  init_done_out,
  output logic                  ram_ce_out,
  output logic                  ram_we_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [BITS-1:0]       ram_wd_out,
  output logic [BITS-1:0]       ram_w_mask_out,
  input  logic [BITS-1:0]       ram_rd_in
);

  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  if (WORD_DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
    $error("fakeram_port_ctrl: WORD_DEPTH does not fit in ADDR_WIDTH");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic                    init_done_q;
  logic                    rd_pending;
  logic                    rd_accept;
  logic [CNT_W-1:0]        occ;

  logic [BITS-1:0]         rsp_buf [RSP_DEPTH];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [CNT_W-1:0]        rsp_cnt;
  logic                    rsp_enq;
  logic                    rsp_deq;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave the sweep after the last word has been written
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (sweep_cnt == LAST_ADDR) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Outputs; everything is held at zero while reset is asserted
  always_comb begin
    req_ready_out  = 1'b0;
    ram_ce_out     = 1'b0;
    ram_we_out     = 1'b0;
    ram_addr_out   = '0;
    ram_wd_out     = '0;
    ram_w_mask_out = '0;
    if (reset_n) begin
      unique case (state)
        ST_INIT: begin
          ram_ce_out     = 1'b1;
          ram_we_out     = 1'b1;
          ram_addr_out   = sweep_cnt;
          ram_wd_out     = '0;
          ram_w_mask_out = '1;
        end
        ST_RUN: begin
          // Credit ignores yumi so there is no combinational yumi->ready path
          req_ready_out = req_we_in | (occ < CNT_W'(RSP_DEPTH));
          if (req_v_in && req_ready_out) begin
            ram_ce_out     = 1'b1;
            ram_we_out     = req_we_in;
            ram_addr_out   = req_addr_in;
            ram_wd_out     = req_data_in;
            ram_w_mask_out = req_mask_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Sweep address counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_q <= 1'(!INIT_ZERO);
    end else begin
      init_done_q <= (state_nxt == ST_RUN);
    end
  end

  assign init_done_out = init_done_q;

  assign rd_accept = ram_ce_out & ~ram_we_out;
  assign occ       = rsp_cnt + CNT_W'(rd_pending);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_accept;
    end
  end

  // Response buffer: macro data lands the cycle after the read, captured at the tail
  assign rsp_enq = rd_pending;
  assign rsp_deq = rsp_yumi_in & (rsp_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        rsp_buf[i] <= '0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      rsp_cnt <= '0;
    end else begin
      if (rsp_enq) begin
        rsp_buf[wr_ptr] <= ram_rd_in;
        wr_ptr          <= ~wr_ptr;
      end
      if (rsp_deq) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({rsp_enq, rsp_deq})
        2'b10:   rsp_cnt <= rsp_cnt + CNT_W'(1);
        2'b01:   rsp_cnt <= rsp_cnt - CNT_W'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  assign rsp_v_out    = (rsp_cnt != '0);
  assign rsp_data_out = rsp_buf[rd_ptr];

  a_no_yumi_when_empty: assert property (
    @(posedge clk) disable iff (!reset_n) rsp_yumi_in |-> (rsp_cnt != '0)
  );

endmodule

// File: tb/tb_fakeram_port_ctrl.sv
// Directed bench for fakeram_port_ctrl with a behavioural single-port macro model.
module tb_fakeram_port_ctrl;

  localparam int unsigned BITS  = 95;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic            clk;
  logic            reset_n;
  logic            req_v_in;
  logic            req_ready_out;
  logic            req_we_in;
  logic [AW-1:0]   req_addr_in;
  logic [BITS-1:0] req_data_in;
  logic [BITS-1:0] req_mask_in;
  logic            rsp_v_out;
  logic [BITS-1:0] rsp_data_out;
  logic            rsp_yumi_in;
  logic            init_done_out;
  logic            ram_ce_out;
  logic            ram_we_out;
  logic [AW-1:0]   ram_addr_out;
  logic [BITS-1:0] ram_wd_out;
  logic [BITS-1:0] ram_w_mask_out;
  logic [BITS-1:0] ram_rd_in;

  int n_checks = 0;
  int n_pass   = 0;

  fakeram_port_ctrl #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_v_in(req_v_in), .req_ready_out(req_ready_out), .req_we_in(req_we_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_mask_in(req_mask_in),
    .rsp_v_out(rsp_v_out), .rsp_data_out(rsp_data_out), .rsp_yumi_in(rsp_yumi_in),
    .init_done_out(init_done_out),
    .ram_ce_out(ram_ce_out), .ram_we_out(ram_we_out), .ram_addr_out(ram_addr_out),
    .ram_wd_out(ram_wd_out), .ram_w_mask_out(ram_w_mask_out), .ram_rd_in(ram_rd_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: memory preset to all ones so only the sweep can make reads return zero
  logic [BITS-1:0] mem [DEPTH];
  logic            model_init = 1'b0;
  always @(posedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '1;
      ram_rd_in  <= '1;
      model_init <= 1'b1;
    end else if (ram_ce_out) begin
      if (ram_we_out) mem[ram_addr_out] <= (mem[ram_addr_out] & ~ram_w_mask_out) | (ram_wd_out & ram_w_mask_out);
      else            ram_rd_in <= mem[ram_addr_out];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [BITS-1:0] d, input logic [BITS-1:0] m);
    req_v_in = v; req_we_in = we; req_addr_in = a; req_data_in = d; req_mask_in = m;
  endtask

  // Release reset and follow the zero-fill sweep word by word
  task automatic check_sweep();
    logic [202:0] got, exp;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      got = {ram_ce_out, ram_we_out, ram_addr_out, ram_wd_out, ram_w_mask_out,
             req_ready_out, init_done_out, rsp_v_out};
      exp = {1'b1, 1'b1, AW'(i), {BITS{1'b0}}, {BITS{1'b1}}, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (got !== exp) $display("FAIL sweep[%0d]: got %h want %h", i, got, exp);
      else n_pass++;
    end
    @(negedge clk); #1;
    n_checks++;
    if ({init_done_out, req_ready_out, ram_ce_out, rsp_v_out} !== 4'b1100)
      $display("FAIL sweep_done: got done/ready/ce/rsp_v=%b want 1100",
               {init_done_out, req_ready_out, ram_ce_out, rsp_v_out});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rsp_yumi_in = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready_out, rsp_v_out, init_done_out, ram_ce_out, ram_we_out} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {req_ready_out, rsp_v_out, init_done_out, ram_ce_out, ram_we_out});
    else n_pass++;
    n_checks++;
    if ({ram_addr_out, ram_wd_out, ram_w_mask_out} !== '0)
      $display("FAIL reset_ram_pins: got %h want 0", {ram_addr_out, ram_wd_out, ram_w_mask_out});
    else n_pass++;
    check_sweep();
  endtask

  task automatic test_read_after_init();
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h7F, '0, '0); #1;
    n_checks++;
    if ({req_ready_out, ram_ce_out, ram_we_out, ram_addr_out} !== {3'b110, 8'h7F})
      $display("FAIL rd7f_issue: got %b_%h want 110_7f",
               {req_ready_out, ram_ce_out, ram_we_out}, ram_addr_out);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0); #1;
    n_checks++;
    if (rsp_v_out !== 1'b0) $display("FAIL rd7f_early: got rsp_v=%b want 0", rsp_v_out);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_v_out, rsp_data_out} !== {1'b1, {BITS{1'b0}}})
      $display("FAIL rd7f_data: got v=%b d=%h want v=1 d=0", rsp_v_out, rsp_data_out);
    else n_pass++;
    rsp_yumi_in = 1'b1;
    @(negedge clk);
    rsp_yumi_in = 1'b0; #1;
    n_checks++;
    if (rsp_v_out !== 1'b0) $display("FAIL rd7f_drain: got rsp_v=%b want 0", rsp_v_out);
    else n_pass++;
  endtask

  task automatic test_masked_write();
    logic [BITS-1:0] w1, exp;
    w1  = 95'h5A5A5A5A5A5A5A5A5A5AA5;
    exp = 95'h5A5A5A5A5A5A5A5A5A5AF5;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd3, w1, '1);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd3, '1, 95'hF0); #1;
    n_checks++;
    if ({ram_ce_out, ram_we_out, ram_w_mask_out} !== {2'b11, 95'hF0})
      $display("FAIL mw_pins: got ce/we=%b mask=%h want 11 f0", {ram_ce_out, ram_we_out}, ram_w_mask_out);
    else n_pass++;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd3, '0, '0); #1;
    n_checks++;
    if (req_ready_out !== 1'b1) $display("FAIL mw_rd_ready: got %b want 1", req_ready_out);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_v_out, rsp_data_out} !== {1'b1, exp})
      $display("FAIL mw_merge: got v=%b d=%h want v=1 d=%h", rsp_v_out, rsp_data_out, exp);
    else n_pass++;
    rsp_yumi_in = 1'b1;
    @(negedge clk);
    rsp_yumi_in = 1'b0;
  endtask

  task automatic prefill(input logic [AW-1:0] a, input logic [BITS-1:0] d);
    @(negedge clk);
    drive(1'b1, 1'b1, a, d, '1); #1;
    n_checks++;
    if (req_ready_out !== 1'b1) $display("FAIL prefill_ready[%0d]: got %b want 1", a, req_ready_out);
    else n_pass++;
  endtask

  task automatic test_credit();
    prefill(8'd20, 95'hA0A0);
    prefill(8'd21, 95'hA1A1);
    prefill(8'd22, 95'hA2A2);
    @(negedge clk); drive(1'b1, 1'b0, 8'd20, '0, '0); #1;
    n_checks++;
    if (req_ready_out !== 1'b1) $display("FAIL cr_rd0: got ready=%b want 1", req_ready_out); else n_pass++;
    @(negedge clk); drive(1'b1, 1'b0, 8'd21, '0, '0); #1;
    n_checks++;
    if (req_ready_out !== 1'b1) $display("FAIL cr_rd1: got ready=%b want 1", req_ready_out); else n_pass++;
    @(negedge clk); drive(1'b1, 1'b0, 8'd22, '0, '0); #1;
    n_checks++;
    if ({req_ready_out, rsp_v_out, rsp_data_out} !== {2'b01, 95'hA0A0})
      $display("FAIL cr_rd2_stall: got ready=%b v=%b d=%h want 0 1 a0a0", req_ready_out, rsp_v_out, rsp_data_out);
    else n_pass++;
    drive(1'b1, 1'b1, 8'd40, '0, '0); #1;
    n_checks++;
    if (req_ready_out !== 1'b1) $display("FAIL cr_wr_pass: got ready=%b want 1", req_ready_out); else n_pass++;
    @(negedge clk); drive(1'b1, 1'b0, 8'd22, '0, '0); rsp_yumi_in = 1'b1; #1;
    n_checks++;
    if ({req_ready_out, rsp_v_out, rsp_data_out} !== {2'b01, 95'hA0A0})
      $display("FAIL cr_full_yumi: got ready=%b v=%b d=%h want 0 1 a0a0", req_ready_out, rsp_v_out, rsp_data_out);
    else n_pass++;
    @(negedge clk); drive(1'b1, 1'b0, 8'd22, '0, '0); rsp_yumi_in = 1'b0; #1;
    n_checks++;
    if ({req_ready_out, rsp_v_out, rsp_data_out} !== {2'b11, 95'hA1A1})
      $display("FAIL cr_rd2_accept: got ready=%b v=%b d=%h want 1 1 a1a1", req_ready_out, rsp_v_out, rsp_data_out);
    else n_pass++;
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); rsp_yumi_in = 1'b1; #1;
    n_checks++;
    if ({rsp_v_out, rsp_data_out} !== {1'b1, 95'hA1A1})
      $display("FAIL cr_head1: got v=%b d=%h want 1 a1a1", rsp_v_out, rsp_data_out);
    else n_pass++;
    // Enqueue and dequeue together: count stays at one, head advances
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_v_out, rsp_data_out} !== {1'b1, 95'hA2A2})
      $display("FAIL cr_head2: got v=%b d=%h want 1 a2a2", rsp_v_out, rsp_data_out);
    else n_pass++;
    @(negedge clk); rsp_yumi_in = 1'b0; #1;
    n_checks++;
    if (rsp_v_out !== 1'b0) $display("FAIL cr_empty: got rsp_v=%b want 0", rsp_v_out); else n_pass++;
  endtask

  // Credit counts the head even while it is being taken, so the third read waits one cycle
  task automatic test_back_to_back();
    logic            req_v [7]   = '{1, 1, 1, 1, 0, 0, 0};
    logic [AW-1:0]   req_a [7]   = '{1, 2, 3, 3, 0, 0, 0};
    logic            exp_rdy [7] = '{1, 1, 0, 1, 0, 0, 0};
    logic            exp_v [7]   = '{0, 0, 1, 1, 0, 1, 0};
    logic [BITS-1:0] exp_d [7]   = '{0, 0, 95'h111, 95'h222, 0, 95'h333, 0};
    prefill(8'd1, 95'h111);
    prefill(8'd2, 95'h222);
    prefill(8'd3, 95'h333);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(req_v[c], 1'b0, req_a[c], '0, '0);
      rsp_yumi_in = rsp_v_out;
      #1;
      if (req_v[c]) begin
        n_checks++;
        if (req_ready_out !== exp_rdy[c])
          $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready_out, exp_rdy[c]);
        else n_pass++;
      end
      n_checks++;
      if (rsp_v_out !== exp_v[c] || (exp_v[c] && rsp_data_out !== exp_d[c]))
        $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want v=%b d=%h", c, rsp_v_out, rsp_data_out, exp_v[c], exp_d[c]);
      else n_pass++;
    end
    rsp_yumi_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, 1'b0, 8'd1, '0, '0);
    @(negedge clk); drive(1'b1, 1'b0, 8'd2, '0, '0);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); #1;
    n_checks++;
    if (rsp_v_out !== 1'b1) $display("FAIL mid_pre: got rsp_v=%b want 1", rsp_v_out); else n_pass++;
    reset_n = 1'b0; #1;
    n_checks++;
    if ({rsp_v_out, req_ready_out, ram_ce_out, init_done_out} !== 4'b0)
      $display("FAIL mid_async: got v/ready/ce/done=%b want 0000",
               {rsp_v_out, req_ready_out, ram_ce_out, init_done_out});
    else n_pass++;
    check_sweep();
    @(negedge clk); #1;
    n_checks++;
    if (rsp_v_out !== 1'b0) $display("FAIL mid_stale: got rsp_v=%b want 0", rsp_v_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_after_init();
    test_masked_write();
    test_credit();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
